// File: rtl/irq_pkg.sv
// Shared types and elaboration-time helpers for the interrupt gateway array.
// The helpers take the source-to-line map flattened to 64 sources x 8 bits.
package irq_pkg;

    typedef enum logic {
        IrqLevel = 1'b0,
        IrqEdge  = 1'b1
    } irq_mode_e;

    localparam int MaxSrc = 64;

    function automatic logic [MaxSrc-1:0] line_src_mask(
        input logic [MaxSrc*8-1:0] src_line,
        input int                  num_src,
        input int                  l
    );
        logic [MaxSrc-1:0] m;
        m = '0;
        for (int i = 0; i < num_src; i++) begin
            if (int'(src_line[i*8 +: 8]) == l) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic line_has_edge(
        input logic [MaxSrc*8-1:0] src_line,
        input logic [MaxSrc-1:0]   src_edge,
        input int                  num_src,
        input int                  l
    );
        return |(line_src_mask(src_line, num_src, l) & src_edge);
    endfunction

    function automatic logic line_has_level(
        input logic [MaxSrc*8-1:0] src_line,
        input logic [MaxSrc-1:0]   src_edge,
        input int                  num_src,
        input int                  l
    );
        return |(line_src_mask(src_line, num_src, l) & ~src_edge);
    endfunction

    function automatic int line_edge_count(
        input logic [MaxSrc*8-1:0] src_line,
        input logic [MaxSrc-1:0]   src_edge,
        input int                  num_src,
        input int                  l
    );
        logic [MaxSrc-1:0] m;
        int                n;
        m = line_src_mask(src_line, num_src, l) & src_edge;
        n = 0;
        for (int i = 0; i < MaxSrc; i++) begin
            if (m[i]) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/irq_gateway_array_if.sv
// Signal bundle between raw device interrupt wires / PLIC and the gateway array.
interface irq_gateway_array_if #(
    parameter int NumSrc   = 8,
    parameter int NumIrqs  = 32,
    parameter int CntWidth = 3
);
    logic [NumSrc-1:0]          irq;
    logic [NumSrc-1:0]          enable;
    logic [NumIrqs-1:0]         ack;
    logic [NumIrqs-1:0]         interrupts;
    logic [NumIrqs-1:0]         edge_trigger;
    logic [NumSrc*CntWidth-1:0] pending;
    logic [NumSrc-1:0]          overflow;

    // Device/PLIC side: drives raw wires, enables and claim acknowledges.
    modport master (
        output irq, enable, ack,
        input  interrupts, edge_trigger, pending, overflow
    );

    // Gateway side.
    modport slave (
        input  irq, enable, ack,
        output interrupts, edge_trigger, pending, overflow
    );
endinterface

// File: rtl/irq_edge_counter.sv
// Edge detector with a saturating pending count drained by claim acknowledges.
module irq_edge_counter #(
    parameter int CntWidth = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                s_i,
    input  logic                enable_i,
    input  logic                ack_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                overflow_o
);
    logic                prev_q, prev_d;
    logic                ovf_q, ovf_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                edge_det, dec, sat;

    always_comb begin
        // prev tracks s even while disabled, so re-enabling a high input is not an edge.
        prev_d   = s_i;
        edge_det = s_i & ~prev_q & enable_i;
        dec      = ack_i & (cnt_q != '0);
        sat      = &cnt_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (edge_det && !dec) begin
            if (sat) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntWidth'(1);
            end
        end else if (!edge_det && dec) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/irq_gateway_array.sv
// Parametrised gateway from raw device IRQ wires onto PLIC interrupt lines:
// synchroniser, polarity, level/edge handling and source-to-line OR mapping.
module irq_gateway_array
    import irq_pkg::*;
#(
    parameter int                     NumSrc       = 8,
    parameter int                     NumIrqs      = 32,
    parameter int                     SyncStages   = 2,
    parameter int                     CntWidth     = 3,
    parameter logic [NumSrc-1:0][7:0] SrcLine      = {8'd8, 8'd7, 8'd6, 8'd5,
                                                      8'd4, 8'd3, 8'd2, 8'd1},
    parameter logic [NumSrc-1:0]      SrcEdge      = '0,
    parameter logic [NumSrc-1:0]      SrcActiveLow = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumSrc-1:0]          irq_i,
    input  logic [NumSrc-1:0]          enable_i,
    input  logic [NumIrqs-1:0]         ack_i,
    output logic [NumIrqs-1:0]         interrupts_o,
    output logic [NumIrqs-1:0]         edge_trigger_o,
    output logic [NumSrc*CntWidth-1:0] pending_o,
    output logic [NumSrc-1:0]          overflow_o
);
    localparam logic [MaxSrc*8-1:0] SrcLineFlat = (MaxSrc*8)'(SrcLine);
    localparam logic [MaxSrc-1:0]   SrcEdgeFlat = MaxSrc'(SrcEdge);

    logic [NumSrc-1:0] s;
    logic [NumSrc-1:0] contrib;
    logic [MaxSrc-1:0] contrib_ext;
    logic              unused_ack;

    // Acks on level lines are deliberately ignored.
    assign unused_ack = ^ack_i;

    for (genvar gi = 0; gi < NumSrc; gi++) begin : g_src
        localparam int        Line = int'(SrcLine[gi]);
        localparam irq_mode_e Mode = SrcEdge[gi] ? IrqEdge : IrqLevel;

        if (Line == 0 || Line >= NumIrqs) begin : g_bad_line
            $error("irq_gateway_array: source %0d mapped to invalid line %0d", gi, Line);
        end

        logic sync_out;
        if (SyncStages == 0) begin : g_nosync
            assign sync_out = irq_i[gi];
        end else begin : g_sync
            logic [SyncStages-1:0] sync_q, sync_d;
            always_comb begin
                sync_d[0] = irq_i[gi];
                for (int k = 1; k < SyncStages; k++) begin
                    sync_d[k] = sync_q[k-1];
                end
            end
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= sync_d;
                end
            end
            assign sync_out = sync_q[SyncStages-1];
        end

        assign s[gi] = sync_out ^ SrcActiveLow[gi];

        if (Mode == IrqEdge) begin : g_edge
            logic [CntWidth-1:0] cnt;
            logic                ovf;
            irq_edge_counter #(
                .CntWidth(CntWidth)
            ) u_cnt (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .s_i        (s[gi]),
                .enable_i   (enable_i[gi]),
                .ack_i      (ack_i[Line]),
                .cnt_o      (cnt),
                .overflow_o (ovf)
            );
            assign pending_o[gi*CntWidth +: CntWidth] = cnt;
            assign overflow_o[gi]                     = ovf;
            assign contrib[gi]                        = (cnt != '0);
        end else begin : g_level
            logic lvl_q, lvl_d;
            assign lvl_d = s[gi] & enable_i[gi];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    lvl_q <= 1'b0;
                end else begin
                    lvl_q <= lvl_d;
                end
            end
            assign pending_o[gi*CntWidth +: CntWidth] = '0;
            assign overflow_o[gi]                     = 1'b0;
            assign contrib[gi]                        = lvl_q;
        end
    end

    assign contrib_ext = MaxSrc'(contrib);

    // Line 0 is reserved by the PLIC.
    assign interrupts_o[0] = 1'b0;

    for (genvar gl = 1; gl < NumIrqs; gl++) begin : g_line
        localparam logic [MaxSrc-1:0] LineMask = line_src_mask(SrcLineFlat, NumSrc, gl);

        if (line_edge_count(SrcLineFlat, SrcEdgeFlat, NumSrc, gl) > 1 ||
            (line_has_edge(SrcLineFlat, SrcEdgeFlat, NumSrc, gl) &&
             line_has_level(SrcLineFlat, SrcEdgeFlat, NumSrc, gl))) begin : g_bad_mix
            $error("irq_gateway_array: line %0d has conflicting edge/level sources", gl);
        end

        assign interrupts_o[gl] = |(contrib_ext & LineMask);
    end

    // Edge sources present a held level, so the PLIC sees every line as level.
    assign edge_trigger_o = '0;

endmodule
